// File: rtl/cpu_seq.sv
// Multi-cycle accumulator CPU core with one shared req/ack memory port.
// Define CPU_SEQ_PERF_EN to add the retire_cnt / stall_cnt performance counters.
module cpu_seq #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int OPC_W    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int OPND_W = DATA_W - OPC_W;

  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_HLT = {OPC_W{1'b1}};

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [DATA_W-1:0] ir, ir_nx;
  logic [DATA_W-1:0] acc, acc_nx;
  logic              z, z_nx;
  logic              c, c_nx;
  logic              req_en;
  logic [DATA_W:0]   sum;

  logic [OPC_W-1:0]  opcode;
  logic [OPND_W-1:0] opnd;
  logic [ADDR_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_d;

  assign opcode = ir[DATA_W-1 -: OPC_W];
  assign opnd   = ir[OPND_W-1:0];
  assign opnd_a = ADDR_W'(opnd);
  assign opnd_d = DATA_W'(opnd);

  // req_en keeps the port quiet for one cycle after reset so a late ack
  // belonging to an aborted transfer can never complete a new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= ADDR_W'(RESET_PC);
      ir     <= '0;
      acc    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      req_en <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      ir     <= ir_nx;
      acc    <= acc_nx;
      z      <= z_nx;
      c      <= c_nx;
      req_en <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    acc_nx   = acc;
    z_nx     = z;
    c_nx     = c;
    sum      = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    unique case (state)
      S_FETCH: begin
        mem_req = req_en;
        if (mem_req && mem_ack) begin
          ir_nx    = mem_rdata;
          pc_nx    = pc + ADDR_W'(1);
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nx = S_FETCH;
        case (opcode)
          OP_LDI: begin
            acc_nx = opnd_d;
            z_nx   = (opnd_d == '0);
          end
          OP_LD, OP_ST, OP_ADD, OP_SUB: state_nx = S_MEM;
          OP_JMP: pc_nx = opnd_a;
          OP_JZ:  if (z) pc_nx = opnd_a;
          OP_HLT: state_nx = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = req_en;
        mem_addr = opnd_a;
        mem_we   = req_en && (opcode == OP_ST);
        if (mem_req && mem_ack) begin
          state_nx = S_FETCH;
          case (opcode)
            OP_LD: begin
              acc_nx = mem_rdata;
              z_nx   = (mem_rdata == '0);
            end
            OP_ADD: begin
              sum    = {1'b0, acc} + {1'b0, mem_rdata};
              acc_nx = sum[DATA_W-1:0];
              c_nx   = sum[DATA_W];
              z_nx   = (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              // C is the carry out of acc + ~mem + 1, i.e. 1 when no borrow.
              sum    = {1'b0, acc} + {1'b0, ~mem_rdata} + {{DATA_W{1'b0}}, 1'b1};
              acc_nx = sum[DATA_W-1:0];
              c_nx   = sum[DATA_W];
              z_nx   = (sum[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

  assign mem_wdata = acc;
  assign pc_out    = pc;
  assign acc_out   = acc;
  assign flag_z    = z;
  assign flag_c    = c;
  assign halted    = (state == S_HALT);

`ifdef CPU_SEQ_PERF_EN
  logic retire;

  // Non-memory ops (HLT included) retire in DECODE; memory ops on their MEM ack.
  assign retire = ((state == S_DECODE) && (state_nx != S_MEM)) ||
                  ((state == S_MEM) && mem_req && mem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      if (mem_req && !mem_ack) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: behavioural RAM with programmable ack delay,
// handshake monitors, and per-scenario tasks with hand-computed expectations.
module tb_cpu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] pc_out, acc_out;
  logic       flag_z, flag_c, halted;
`ifdef CPU_SEQ_PERF_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cpu_seq dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_out(pc_out), .acc_out(acc_out), .flag_z(flag_z), .flag_c(flag_c),
    .halted(halted)
`ifdef CPU_SEQ_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255];
  int   wait_cyc  = 0;
  logic force_ack = 1'b0;
  int   wcnt      = 0;
  int   wr_count  = 0;
  int   cyc       = 0;

  assign mem_ack   = force_ack | (mem_req && (wcnt >= wait_cyc));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req === 1'b1 && mem_ack === 1'b0) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req === 1'b1 && mem_ack === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  // ---------------- monitors ----------------
  int         ack_cyc[$];
  logic [7:0] ack_addr[$];
  logic       ack_we[$];
  logic [7:0] exp_q[$];
  int         stab_chk = 0, stab_err = 0, stall_obs = 0;
  logic       prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [7:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      ack_cyc.push_back(cyc);
      ack_addr.push_back(mem_addr);
      ack_we.push_back(mem_we);
    end
    if (mem_req === 1'b1 && mem_ack === 1'b0) stall_obs = stall_obs + 1;
    if (mem_req === 1'b1 && prev_req && !prev_ack) begin
      stab_chk = stab_chk + 1;
      if (mem_addr !== prev_addr || mem_we !== prev_we || (mem_we && mem_wdata !== prev_wdata))
        stab_err = stab_err + 1;
    end
    prev_req   = (mem_req === 1'b1);
    prev_ack   = (mem_ack === 1'b1);
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst       = 1'b1;
    force_ack = 1'b0;
    wait_cyc  = 0;
    tick();
    tick();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic release_reset();
    ack_cyc.delete();
    ack_addr.delete();
    ack_we.delete();
    stab_chk  = 0;
    stab_err  = 0;
    stall_obs = 0;
    wr_count  = 0;
    rst       = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_chk++; if (halted !== 1'b1) $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, want 1", name, halted, k); else n_pass++;
  endtask

  task automatic check_seq(input string name);
    logic ok;
    ok = (ack_addr.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (ack_addr[i] !== exp_q[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL %s_ack_addrs: got %p want %p", name, ack_addr, exp_q); else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (pc_out !== 8'h00) $display("FAIL rst_pc: got %h want 00", pc_out); else n_pass++;
    n_chk++; if (acc_out !== 8'h00) $display("FAIL rst_acc: got %h want 00", acc_out); else n_pass++;
    n_chk++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {flag_z, flag_c}); else n_pass++;
    n_chk++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else n_pass++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_req_after: got %b want 0", mem_req); else n_pass++;
    tick();
    n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL rst_first_fetch: req=%b we=%b want 1 0", mem_req, mem_we); else n_pass++;
    n_chk++; if (mem_addr !== 8'h00) $display("FAIL rst_fetch_addr: got %h want 00", mem_addr); else n_pass++;
  endtask

  // LDI 5; ADD [0A]; ST [0B]; HLT with mem[0A]=3
  task automatic load_prog1();
    mem[8'h00] = 8'h15;
    mem[8'h01] = 8'h4A;
    mem[8'h02] = 8'h3B;
    mem[8'h03] = 8'hF0;
    mem[8'h0A] = 8'h03;
  endtask

  task automatic check_prog1_final(input string name);
    n_chk++; if (mem[8'h0B] !== 8'h08) $display("FAIL %s_st_data: got %h want 08", name, mem[8'h0B]); else n_pass++;
    n_chk++; if (acc_out !== 8'h08) $display("FAIL %s_acc: got %h want 08", name, acc_out); else n_pass++;
    n_chk++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL %s_flags: got %b want 00", name, {flag_z, flag_c}); else n_pass++;
    n_chk++; if (pc_out !== 8'h04) $display("FAIL %s_pc: got %h want 04", name, pc_out); else n_pass++;
  endtask

  task automatic check_prog1_timing(input string name, input int l_ldi, input int l_mem);
    n_chk++;
    if (ack_cyc.size() != 6) $display("FAIL %s_ack_count: got %0d want 6", name, ack_cyc.size());
    else begin
      n_pass++;
      n_chk++; if (ack_cyc[1] - ack_cyc[0] != l_ldi) $display("FAIL %s_lat_ldi: got %0d want %0d", name, ack_cyc[1] - ack_cyc[0], l_ldi); else n_pass++;
      n_chk++; if (ack_cyc[3] - ack_cyc[1] != l_mem) $display("FAIL %s_lat_add: got %0d want %0d", name, ack_cyc[3] - ack_cyc[1], l_mem); else n_pass++;
      n_chk++; if (ack_cyc[5] - ack_cyc[3] != l_mem) $display("FAIL %s_lat_st: got %0d want %0d", name, ack_cyc[5] - ack_cyc[3], l_mem); else n_pass++;
      n_chk++; if (ack_we[4] !== 1'b1 || ack_we[2] !== 1'b0) $display("FAIL %s_we_seq: got %b%b want 01", name, ack_we[2], ack_we[4]); else n_pass++;
    end
  endtask

  task automatic test_prog1();
    hold_reset();
    load_prog1();
    release_reset();
    run_to_halt("p1", 100);
    check_prog1_final("p1");
    exp_q = '{8'h00, 8'h01, 8'h0A, 8'h02, 8'h0B, 8'h03};
    check_seq("p1");
    check_prog1_timing("p1", 2, 3);
    n_chk++; if (wr_count != 1) $display("FAIL p1_writes: got %0d want 1", wr_count); else n_pass++;
  endtask

  task automatic test_sub();
    logic [7:0] a_init [2] = '{8'h13, 8'h12};
    logic [7:0] a_exp  [2] = '{8'h00, 8'hFF};
    logic [1:0] zc_exp [2] = '{2'b11, 2'b00};
    for (int t = 0; t < 2; t++) begin
      hold_reset();
      mem[8'h00] = a_init[t];
      mem[8'h01] = 8'h5A;
      mem[8'h02] = 8'hF0;
      mem[8'h0A] = 8'h03;
      release_reset();
      run_to_halt("sub", 100);
      n_chk++; if (acc_out !== a_exp[t]) $display("FAIL sub%0d_acc: got %h want %h", t, acc_out, a_exp[t]); else n_pass++;
      n_chk++; if ({flag_z, flag_c} !== zc_exp[t]) $display("FAIL sub%0d_zc: got %b want %b", t, {flag_z, flag_c}, zc_exp[t]); else n_pass++;
    end
  endtask

  // LDI 15; ADD [0A]=F8 -> 07 C=1; NOP(opc 8); LD [0C]=0 -> Z=1 C kept; ST [0D]; HLT
  task automatic test_add_ld_st_flags();
    hold_reset();
    mem[8'h00] = 8'h1F;
    mem[8'h01] = 8'h4A;
    mem[8'h02] = 8'h85;
    mem[8'h03] = 8'h2C;
    mem[8'h04] = 8'h3D;
    mem[8'h05] = 8'hF0;
    mem[8'h0A] = 8'hF8;
    mem[8'h0D] = 8'h55;
    release_reset();
    run_to_halt("ald", 100);
    n_chk++; if (acc_out !== 8'h00) $display("FAIL ald_acc: got %h want 00", acc_out); else n_pass++;
    n_chk++; if (flag_z !== 1'b1) $display("FAIL ald_z: got %b want 1", flag_z); else n_pass++;
    n_chk++; if (flag_c !== 1'b1) $display("FAIL ald_c_kept: got %b want 1", flag_c); else n_pass++;
    n_chk++; if (mem[8'h0D] !== 8'h00) $display("FAIL ald_st: got %h want 00", mem[8'h0D]); else n_pass++;
    n_chk++; if (pc_out !== 8'h06) $display("FAIL ald_pc: got %h want 06", pc_out); else n_pass++;
  endtask

  task automatic test_jz();
    logic [7:0] ldi  [2] = '{8'h10, 8'h11};
    logic [7:0] pc_x [2] = '{8'h0A, 8'h03};
    for (int t = 0; t < 2; t++) begin
      hold_reset();
      mem[8'h00] = ldi[t];
      mem[8'h01] = 8'h79;
      mem[8'h02] = 8'hF0;
      mem[8'h09] = 8'hF0;
      release_reset();
      run_to_halt("jz", 100);
      if (t == 0) exp_q = '{8'h00, 8'h01, 8'h09};
      else        exp_q = '{8'h00, 8'h01, 8'h02};
      check_seq($sformatf("jz%0d", t));
      n_chk++; if (pc_out !== pc_x[t]) $display("FAIL jz%0d_pc: got %h want %h", t, pc_out, pc_x[t]); else n_pass++;
    end
  endtask

  task automatic test_jmp_wrap();
    int k = 0;
    int n;
    hold_reset();
    mem[8'hFF] = 8'h6F;
    release_reset();
    while (!(ack_addr.size() > 0 && ack_addr[$] == 8'hFF) && k < 1000) begin
      tick();
      k++;
    end
    n_chk++; if (ack_addr.size() == 0 || ack_addr[$] != 8'hFF) $display("FAIL wrap_reach_ff: timeout after %0d cycles", k); else n_pass++;
    n_chk++; if (pc_out !== 8'h00) $display("FAIL wrap_pc_inc: got %h want 00", pc_out); else n_pass++;
    n = ack_addr.size();
    k = 0;
    while (ack_addr.size() == n && k < 20) begin
      tick();
      k++;
    end
    n_chk++; if (ack_addr.size() == n || ack_addr[$] !== 8'h0F) $display("FAIL wrap_jmp_target: got %h want 0f", ack_addr[$]); else n_pass++;
  endtask

  task automatic test_wait_states();
    hold_reset();
    load_prog1();
    wait_cyc = 3;
    release_reset();
    run_to_halt("ws", 300);
    check_prog1_final("ws");
    check_prog1_timing("ws", 5, 9);
    n_chk++; if (!(stab_chk > 0) || stab_err != 0) $display("FAIL ws_stable: errors %0d of %0d want 0", stab_err, stab_chk); else n_pass++;
    n_chk++; if (stall_obs != 18) $display("FAIL ws_stall_obs: got %0d want 18", stall_obs); else n_pass++;
`ifdef CPU_SEQ_PERF_EN
    n_chk++; if (retire_cnt !== 32'd4) $display("FAIL perf_retire: got %0d want 4", retire_cnt); else n_pass++;
    n_chk++; if (stall_cnt !== 32'd18) $display("FAIL perf_stall: got %0d want 18", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_st();
    int k = 0;
    hold_reset();
    wait_cyc = 100;
    mem[8'h00] = 8'h17;
    mem[8'h01] = 8'h3B;
    mem[8'h0B] = 8'hAA;
    release_reset();
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && k < 400) begin
      tick();
      k++;
    end
    n_chk++; if (mem_we !== 1'b1 || mem_addr !== 8'h0B) $display("FAIL rmid_reach_st: we=%b addr=%h want 1 0b", mem_we, mem_addr); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_ack = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rmid_req: got %b want 0", mem_req); else n_pass++;
    n_chk++; if (pc_out !== 8'h00) $display("FAIL rmid_pc: got %h want 00", pc_out); else n_pass++;
    n_chk++; if (acc_out !== 8'h00) $display("FAIL rmid_acc: got %h want 00", acc_out); else n_pass++;
    tick();
    force_ack = 1'b0;
    #1;
    n_chk++; if (mem[8'h0B] !== 8'hAA || wr_count != 0) $display("FAIL rmid_no_write: mem=%h writes=%0d want aa 0", mem[8'h0B], wr_count); else n_pass++;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) $display("FAIL rmid_refetch: req=%b addr=%h we=%b want 1 00 0", mem_req, mem_addr, mem_we); else n_pass++;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_prog1();
    test_sub();
    test_add_ld_st_flags();
    test_jz();
    test_jmp_wrap();
    test_wait_states();
    test_reset_mid_st();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
